// File: rtl/dac_spi_pkg.sv
// rtl/dac_spi_pkg.sv - shared state encoding, frame layout and command codes for the DAC SPI arbiter
package dac_spi_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam int CMD_W    = 4;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 12;
    localparam int FRAME_W  = 32;

    // Field offsets inside the 32-bit frame {8'h00, cmd, addr, data, 4'h0}
    localparam int CMD_LSB  = 20;
    localparam int ADDR_LSB = 16;
    localparam int DATA_LSB = 4;

    // One shared phase counter covers reset hold, WAIT timeout and GAP
    localparam int CNT_W    = 16;

    localparam logic [CMD_W-1:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_POWER_DOWN   = 4'b0100;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [CMD_W-1:0]  cmd,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_W-1:0] f;
        f = '0;
        f[CMD_LSB  +: CMD_W]  = cmd;
        f[ADDR_LSB +: ADDR_W] = addr;
        f[DATA_LSB +: DATA_W] = data;
        return f;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin selector, the requester not granted last wins a tie
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Index of the most recent grant; starts at 1 so requester 0 wins the first tie
    logic last_q;

    // Combinational pick: single requester wins outright, a tie goes to the other side of last_q
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner only when the caller actually commits the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/dac_spi_arbiter.sv
// rtl/dac_spi_arbiter.sv - arbitrates two DAC writers onto one SPI master with reset hold, gap and timeout
module dac_spi_arbiter
    import dac_spi_pkg::*;
#(
    parameter int RESET_HOLD = 16,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic               req1,
    input  logic [CMD_W-1:0]   cmd0,
    input  logic [CMD_W-1:0]   cmd1,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [DATA_W-1:0]  data0,
    input  logic [DATA_W-1:0]  data1,
    output logic               gnt0,
    output logic               gnt1,
    output logic [FRAME_W-1:0] toSPI,
    output logic               toEnable,
    output logic               toReset,
    input  logic               spi_busy,
    input  logic               spi_done,
    output logic               busy,
    output logic               err_timeout
);

    // Terminal counts: each phase ends on the cycle its counter shows the last value
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               winner_q, winner_d;
    logic               err_q, err_d;
    logic [1:0]         arb_gnt;
    logic               arb_advance;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (reset),
        .req     ({req1, req0}),
        .advance (arb_advance),
        .gnt     (arb_gnt)
    );

    // State, counter, latched frame, winner and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            frame_q  <= '0;
            winner_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            winner_q <= winner_d;
            err_q    <= err_d;
        end
    end

    // Next-state: hold reset, grant from IDLE, pulse ISSUE, wait for done or time out, then gap
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        winner_d    = winner_q;
        err_d       = err_q;
        arb_advance = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_IDLE: begin
                if ((req0 || req1) && !spi_busy) begin
                    arb_advance = 1'b1;
                    winner_d    = arb_gnt[1];
                    frame_d     = arb_gnt[1] ? build_frame(cmd1, addr1, data1)
                                             : build_frame(cmd0, addr0, data0);
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (spi_done) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    // Abort: the SPI side is re-reset through a full INIT
                    err_d   = 1'b1;
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset forces them without glitches
    always_comb begin
        toEnable    = (state_q == ST_ISSUE);
        gnt0        = (state_q == ST_ISSUE) && !winner_q;
        gnt1        = (state_q == ST_ISSUE) && winner_q;
        toReset     = (state_q == ST_INIT);
        busy        = (state_q != ST_IDLE);
        toSPI       = frame_q;
        err_timeout = err_q;
    end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// tb/tb_dac_spi_arbiter.sv - self-checking bench for dac_spi_arbiter
module tb_dac_spi_arbiter;

    localparam int RESET_HOLD = 16;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 1024;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [3:0]  cmd0, cmd1, addr0, addr1;
    logic [11:0] data0, data1;
    logic        gnt0, gnt1;
    logic [31:0] toSPI;
    logic        toEnable, toReset;
    logic        spi_busy, spi_done;
    logic        busy, err_timeout;

    int total;
    int bad;
    int m_last;

    dac_spi_arbiter #(
        .RESET_HOLD (RESET_HOLD),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .cmd0        (cmd0),
        .cmd1        (cmd1),
        .addr0       (addr0),
        .addr1       (addr1),
        .data0       (data0),
        .data1       (data1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .toSPI       (toSPI),
        .toEnable    (toEnable),
        .toReset     (toReset),
        .spi_busy    (spi_busy),
        .spi_done    (spi_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] exp_frame(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
        return {8'h00, c, a, d, 4'h0};
    endfunction

    // Reference arbitration: pattern bit0=req0, bit1=req1; returns winner index and updates history
    function automatic int pick(input int pat);
        int w;
        if (pat == 3) w = (m_last == 1) ? 0 : 1;
        else          w = (pat == 2) ? 1 : 0;
        m_last = w;
        return w;
    endfunction

    // Counts negedges until toEnable is seen (bounded)
    task automatic wait_issue(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!toEnable && n < 200);
    endtask

    // SPI master stand-in: busy for lat cycles, then one spi_done pulse
    task automatic run_wait(input int lat);
        spi_busy = 1'b1;
        repeat (lat) @(negedge clk);
        spi_busy = 1'b0;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
    endtask

    // Counts consecutive busy cycles starting from the cycle after spi_done
    task automatic count_gap(output int n);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int n;
        reset = 1'b0;
        @(negedge clk);
        total++; if (toReset !== 1'b1) begin bad++; $display("FAIL rst_toReset got %b want 1", toReset); end
        total++; if ({toEnable, gnt0, gnt1} !== 3'b000) begin bad++; $display("FAIL rst_pulses got %b want 000", {toEnable, gnt0, gnt1}); end
        total++; if (toSPI !== 32'h0) begin bad++; $display("FAIL rst_toSPI got %h want 0", toSPI); end
        total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", err_timeout); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got %b want 1", busy); end
        reset  = 1'b1;
        m_last = 1;
        n = 0;
        while (toReset && n < 50) begin
            n++;
            @(negedge clk);
        end
        total++; if (n !== RESET_HOLD) begin bad++; $display("FAIL init_hold got %0d want %0d", n, RESET_HOLD); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL init_busy got %b want 0", busy); end
        total++; if (toSPI !== 32'h0) begin bad++; $display("FAIL init_toSPI got %h want 0", toSPI); end
    endtask

    task automatic test_single_write;
        int n;
        cmd0 = 4'd3; addr0 = 4'd1; data0 = 12'hABC;
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        void'(pick(1));
        total++; if ({toEnable, gnt0, gnt1} !== 3'b110) begin bad++; $display("FAIL single_issue got %b want 110", {toEnable, gnt0, gnt1}); end
        total++; if (toSPI !== 32'h0031ABC0) begin bad++; $display("FAIL single_frame got %h want 0031abc0", toSPI); end
        run_wait(40);
        count_gap(n);
        total++; if (n !== GAP_CYCLES) begin bad++; $display("FAIL single_gap got %0d want %0d", n, GAP_CYCLES); end
        total++; if (toSPI !== 32'h0031ABC0) begin bad++; $display("FAIL single_hold got %h want 0031abc0", toSPI); end
    endtask

    task automatic test_random_writes;
        int pat, w, n, lat;
        logic [31:0] ef;
        for (int it = 0; it < 8; it++) begin
            pat   = $urandom_range(1, 3);
            cmd0  = (it % 2 == 0) ? 4'b0011 : 4'($urandom);
            cmd1  = (it % 3 == 0) ? 4'b0100 : 4'($urandom);
            addr0 = 4'($urandom); addr1 = 4'($urandom);
            data0 = 12'($urandom); data1 = 12'($urandom);
            req0  = pat[0];
            req1  = pat[1];
            @(negedge clk);
            w  = pick(pat);
            ef = (w == 1) ? exp_frame(cmd1, addr1, data1) : exp_frame(cmd0, addr0, data0);
            req0 = 1'b0; req1 = 1'b0;
            total++; if ({toEnable, gnt0, gnt1} !== {1'b1, w == 0, w == 1}) begin bad++;
                $display("FAIL rand_gnt it=%0d pat=%0d got %b want %b", it, pat, {toEnable, gnt0, gnt1}, {1'b1, w == 0, w == 1}); end
            total++; if (toSPI !== ef) begin bad++; $display("FAIL rand_frame it=%0d got %h want %h", it, toSPI, ef); end
            lat = $urandom_range(1, 30);
            run_wait(lat);
            count_gap(n);
            total++; if (n !== GAP_CYCLES) begin bad++; $display("FAIL rand_gap it=%0d got %0d want %0d", it, n, GAP_CYCLES); end
            @(negedge clk);
            total++; if ({toEnable, busy, toSPI} !== {2'b00, ef}) begin bad++;
                $display("FAIL rand_idle it=%0d got en=%b busy=%b spi=%h want en=0 busy=0 spi=%h", it, toEnable, busy, toSPI, ef); end
        end
    endtask

    task automatic test_back_to_back;
        int n, w;
        logic [31:0] ef;
        cmd0 = 4'b0011; addr0 = 4'd2; data0 = 12'($urandom);
        cmd1 = 4'b0100; addr1 = 4'd7; data1 = 12'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_issue(n);
            // first frame follows the request by one cycle; later ones by the gap plus the IDLE decision cycle
            total++; if (n !== ((f == 0) ? 1 : GAP_CYCLES + 1)) begin bad++;
                $display("FAIL b2b_spacing f=%0d got %0d want %0d", f, n, (f == 0) ? 1 : GAP_CYCLES + 1); end
            w  = pick(3);
            ef = (w == 1) ? exp_frame(cmd1, addr1, data1) : exp_frame(cmd0, addr0, data0);
            total++; if ({gnt0, gnt1, toSPI} !== {w == 0, w == 1, ef}) begin bad++;
                $display("FAIL b2b_grant f=%0d got g=%b%b spi=%h want g=%b%b spi=%h", f, gnt0, gnt1, toSPI, w == 0, w == 1, ef); end
            if (f == 3) begin req0 = 1'b0; req1 = 1'b0; end
            run_wait($urandom_range(2, 12));
        end
        count_gap(n);
        total++; if (n !== GAP_CYCLES) begin bad++; $display("FAIL b2b_lastgap got %0d want %0d", n, GAP_CYCLES); end
    endtask

    task automatic test_busy_block;
        int seen;
        logic [31:0] ef;
        cmd1 = 4'($urandom); addr1 = 4'($urandom); data1 = 12'($urandom);
        ef = exp_frame(cmd1, addr1, data1);
        spi_busy = 1'b1;
        req1 = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            spi_done = (i == 2);
            @(negedge clk);
            if (toEnable || gnt1 || busy) seen++;
        end
        spi_done = 1'b0;
        total++; if (seen !== 0) begin bad++; $display("FAIL busy_block got %0d activity cycles want 0", seen); end
        spi_busy = 1'b0;
        @(negedge clk);
        req1 = 1'b0;
        void'(pick(2));
        total++; if ({toEnable, gnt0, gnt1, toSPI} !== {3'b101, ef}) begin bad++;
            $display("FAIL busy_release got %b spi=%h want 101 spi=%h", {toEnable, gnt0, gnt1}, toSPI, ef); end
        run_wait(5);
        count_gap(seen);
    endtask

    task automatic test_timeout;
        int n, stray;
        cmd0 = 4'($urandom); addr0 = 4'($urandom); data0 = 12'($urandom);
        req0 = 1'b1;
        @(negedge clk);
        void'(pick(1));
        total++; if ({toEnable, gnt0} !== 2'b11) begin bad++; $display("FAIL to_issue got %b want 11", {toEnable, gnt0}); end
        req0 = 1'b0;
        req1 = 1'b1;
        cmd1 = 4'($urandom); addr1 = 4'($urandom); data1 = 12'($urandom);
        n = 0;
        @(negedge clk);
        while (!err_timeout && n < 2000) begin
            n++;
            @(negedge clk);
        end
        total++; if (n !== TIMEOUT) begin bad++; $display("FAIL to_wait_cycles got %0d want %0d", n, TIMEOUT); end
        n = 0; stray = 0;
        while (toReset && n < 50) begin
            if (toEnable || gnt1) stray++;
            n++;
            @(negedge clk);
        end
        total++; if (n !== RESET_HOLD) begin bad++; $display("FAIL to_rehold got %0d want %0d", n, RESET_HOLD); end
        total++; if ({stray, toEnable} !== {32'd0, 1'b0}) begin bad++; $display("FAIL to_early_grant got %0d/%b want 0/0", stray, toEnable); end
        @(negedge clk);
        void'(pick(2));
        total++; if ({toEnable, gnt1, toSPI} !== {2'b11, exp_frame(cmd1, addr1, data1)}) begin bad++;
            $display("FAIL to_pending got %b%b spi=%h want 11 spi=%h", toEnable, gnt1, toSPI, exp_frame(cmd1, addr1, data1)); end
        req1 = 1'b0;
        run_wait(3);
        count_gap(n);
        total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got %b want 1", err_timeout); end
    endtask

    task automatic test_reset_midframe;
        int n, stray;
        cmd1 = 4'($urandom); addr1 = 4'($urandom); data1 = 12'($urandom);
        req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        void'(pick(2));
        total++; if ({toEnable, gnt1} !== 2'b11) begin bad++; $display("FAIL mid_issue got %b want 11", {toEnable, gnt1}); end
        spi_busy = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if ({toEnable, gnt0, gnt1, toReset, busy, err_timeout} !== 6'b000110) begin bad++;
            $display("FAIL mid_async got en/g0/g1/rst/busy/err=%b want 000110", {toEnable, gnt0, gnt1, toReset, busy, err_timeout}); end
        total++; if (toSPI !== 32'h0) begin bad++; $display("FAIL mid_toSPI got %h want 0", toSPI); end
        @(negedge clk);
        spi_busy = 1'b0;
        reset    = 1'b1;
        m_last   = 1;
        n = 0; stray = 0;
        while (toReset && n < 50) begin
            spi_done = (n == 3);
            if (toEnable || gnt0 || gnt1) stray++;
            n++;
            @(negedge clk);
        end
        spi_done = 1'b0;
        total++; if (n !== RESET_HOLD || stray !== 0) begin bad++; $display("FAIL mid_rehold got %0d/%0d want %0d/0", n, stray, RESET_HOLD); end
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        @(negedge clk);
        total++; if ({busy, toEnable} !== 2'b00) begin bad++; $display("FAIL mid_stray_done got busy=%b en=%b want 00", busy, toEnable); end
        cmd0 = 4'b0011; addr0 = 4'($urandom); data0 = 12'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        n = pick(3);
        total++; if ({gnt0, gnt1} !== {n == 0, n == 1} || toSPI !== exp_frame(cmd0, addr0, data0)) begin bad++;
            $display("FAIL mid_first_tie got %b%b spi=%h want %b%b", gnt0, gnt1, toSPI, n == 0, n == 1); end
        run_wait(4);
        count_gap(n);
    endtask

    initial begin
        total = 0; bad = 0; m_last = 1;
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        cmd0 = '0; cmd1 = '0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        spi_busy = 1'b0; spi_done = 1'b0;
        test_reset();
        test_single_write();
        test_random_writes();
        test_back_to_back();
        test_busy_block();
        test_timeout();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
